vcve2_vec_seq: RTL and testbench

Vector element sequencer sitting directly upstream of `vcve2_ex_block`. It accepts one vector arithmetic instruction from ID, walks the destination register 32-bit word by word, and reads `vs1`/`vs2` (or splats a scalar) from the vector register file (VRF). It presents each word pair to the EX block as ALU operands and writes each EX result back to `vd` with byte enables that protect tail bytes. LMUL=1 only; one instruction in flight.

---
 rtl/vcve2_pkg.sv | 31 +++
 rtl/vcve2_vec_splat.sv | 19 +
 rtl/vcve2_vec_seq.sv | 151 +++++++++++++++
 tb/tb_vcve2_vec_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
// Shared vcve2 types: ALU operations, vector element widths and sequencer states.
package vcve2_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_OR  = 4'd3,
    ALU_AND = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;

  localparam logic [2:0] VSEW_E8  = 3'd0;
  localparam logic [2:0] VSEW_E16 = 3'd1;
  localparam logic [2:0] VSEW_E32 = 3'd2;

  typedef enum logic [2:0] {
    VSEQ_IDLE = 3'd0,
    VSEQ_RD   = 3'd1,
    VSEQ_EX   = 3'd2,
    VSEQ_WB   = 3'd3,
    VSEQ_FIN  = 3'd4
  } vseq_state_e;

  function automatic logic vsew_legal(input logic [2:0] vsew);
    return vsew <= VSEW_E32;
  endfunction

endpackage

// File: rtl/vcve2_vec_splat.sv
// Replicates the low element of a scalar across a 32-bit word for .vx operand B.
module vcve2_vec_splat
  import vcve2_pkg::*;
(
  input  logic [31:0] i_scalar,
  input  logic [2:0]  i_vsew,
  output logic [31:0] o_splat
);

  always_comb begin
    o_splat = i_scalar;
    case (i_vsew)
      VSEW_E8:  o_splat = {4{i_scalar[7:0]}};
      VSEW_E16: o_splat = {2{i_scalar[15:0]}};
      default:  o_splat = i_scalar;
    endcase
  end

endmodule

// File: rtl/vcve2_vec_seq.sv
// Vector element sequencer: walks vd word by word, feeding EX and writing results back
// with tail-protecting byte enables. LMUL=1, one instruction in flight.
module vcve2_vec_seq
  import vcve2_pkg::*;
#(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned WIDX_W = $clog2(VLEN/32),
  parameter int unsigned VL_W   = $clog2(VLEN/8) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                kill_i,
  input  logic [4:0]          vs1_i,
  input  logic [4:0]          vs2_i,
  input  logic [4:0]          vd_i,
  input  logic                vx_i,
  input  logic [31:0]         scalar_i,
  input  logic [VL_W-1:0]     vl_i,
  input  logic [2:0]          vsew_i,
  input  alu_op_e             alu_op_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                vrf_re_o,
  output logic [5+WIDX_W-1:0] vrf_raddr_a_o,
  output logic [5+WIDX_W-1:0] vrf_raddr_b_o,
  input  logic [31:0]         vrf_rdata_a_i,
  input  logic [31:0]         vrf_rdata_b_i,
  output logic                vrf_we_o,
  output logic [5+WIDX_W-1:0] vrf_waddr_o,
  output logic [31:0]         vrf_wdata_o,
  output logic [3:0]          vrf_wbe_o,
  output logic [31:0]         ex_operand_a_o,
  output logic [31:0]         ex_operand_b_o,
  output alu_op_e             ex_alu_op_o,
  output logic                ex_vec_instr_o,
  output logic [2:0]          ex_vsew_o,
  input  logic                ex_valid_i,
  input  logic [31:0]         ex_result_i
);

  localparam logic [VL_W-1:0] VLMAX_E8 = VL_W'(VLEN/8);

  vseq_state_e       r_state, w_state_nxt;
  logic [WIDX_W-1:0] r_widx;
  logic [4:0]        r_vs1, r_vs2, r_vd;
  logic              r_vx, r_err;
  logic [31:0]       r_scalar, r_result;
  logic [2:0]        r_vsew;
  alu_op_e           r_alu_op;
  logic [VL_W-1:0]   r_nbytes;

  logic [VL_W-1:0]   w_vlmax, w_vl_eff, w_nbytes, w_rem;
  logic              w_illegal, w_accept, w_last;
  logic [3:0]        w_be;
  logic [31:0]       w_splat;

  assign w_illegal = !vsew_legal(vsew_i);
  assign w_vlmax   = VLMAX_E8 >> vsew_i[1:0];
  assign w_vl_eff  = (vl_i < w_vlmax) ? vl_i : w_vlmax;
  assign w_nbytes  = w_vl_eff << vsew_i[1:0];
  assign w_accept  = (r_state == VSEQ_IDLE) && start_i && !kill_i;

  // Bytes still owed to vd from the current word on; <= 4 means this is the last word.
  assign w_rem  = r_nbytes - (VL_W'(r_widx) << 2);
  assign w_last = (w_rem <= VL_W'(4));

  always_comb begin
    w_be = 4'hF;
    if (w_rem < VL_W'(4)) begin
      case (w_rem[1:0])
        2'd1:    w_be = 4'b0001;
        2'd2:    w_be = 4'b0011;
        2'd3:    w_be = 4'b0111;
        default: w_be = 4'b0000;
      endcase
    end
  end

  vcve2_vec_splat u_splat (
    .i_scalar (r_scalar),
    .i_vsew   (r_vsew),
    .o_splat  (w_splat)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VSEQ_IDLE: if (start_i) w_state_nxt = (w_illegal || w_vl_eff == '0) ? VSEQ_FIN : VSEQ_RD;
      VSEQ_RD:   w_state_nxt = VSEQ_EX;
      VSEQ_EX:   if (ex_valid_i) w_state_nxt = VSEQ_WB;
      VSEQ_WB:   w_state_nxt = w_last ? VSEQ_FIN : VSEQ_RD;
      VSEQ_FIN:  w_state_nxt = VSEQ_IDLE;
      default:   w_state_nxt = VSEQ_IDLE;
    endcase
    if (kill_i) w_state_nxt = VSEQ_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= VSEQ_IDLE;
      r_widx   <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_vx     <= 1'b0;
      r_err    <= 1'b0;
      r_scalar <= '0;
      r_result <= '0;
      r_vsew   <= '0;
      r_alu_op <= ALU_ADD;
      r_nbytes <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vs1    <= vs1_i;
        r_vs2    <= vs2_i;
        r_vd     <= vd_i;
        r_vx     <= vx_i;
        r_scalar <= scalar_i;
        r_vsew   <= vsew_i;
        r_alu_op <= alu_op_i;
        r_nbytes <= w_nbytes;
        r_err    <= w_illegal;
        r_widx   <= '0;
      end
      if (r_state == VSEQ_EX && ex_valid_i && !kill_i) r_result <= ex_result_i;
      if (r_state == VSEQ_WB && !kill_i) r_widx <= r_widx + 1'b1;
    end
  end

  always_comb begin
    busy_o         = (r_state == VSEQ_RD) || (r_state == VSEQ_EX) || (r_state == VSEQ_WB);
    done_o         = (r_state == VSEQ_FIN) && !kill_i;
    err_o          = (r_state == VSEQ_FIN) && !kill_i && r_err;
    vrf_re_o       = (r_state == VSEQ_RD);
    vrf_raddr_a_o  = vrf_re_o ? {r_vs1, r_widx} : '0;
    vrf_raddr_b_o  = vrf_re_o ? {r_vs2, r_widx} : '0;
    vrf_we_o       = (r_state == VSEQ_WB) && !kill_i;
    vrf_waddr_o    = (r_state == VSEQ_WB) ? {r_vd, r_widx} : '0;
    vrf_wdata_o    = (r_state == VSEQ_WB) ? r_result : '0;
    vrf_wbe_o      = (r_state == VSEQ_WB) ? w_be : '0;
    ex_vec_instr_o = (r_state == VSEQ_EX);
    ex_operand_a_o = ex_vec_instr_o ? vrf_rdata_a_i : '0;
    ex_operand_b_o = ex_vec_instr_o ? (r_vx ? w_splat : vrf_rdata_b_i) : '0;
    ex_alu_op_o    = r_alu_op;
    ex_vsew_o      = r_vsew;
  end

endmodule

// File: tb/tb_vcve2_vec_seq.sv
// Scoreboard bench for vcve2_vec_seq with a behavioural VRF and a stallable EX stub.
module tb_vcve2_vec_seq;
  import vcve2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni, start_i, kill_i, vx_i;
  logic [4:0]  vs1_i, vs2_i, vd_i;
  logic [31:0] scalar_i;
  logic [4:0]  vl_i;
  logic [2:0]  vsew_i;
  alu_op_e     alu_op_i;
  logic        busy_o, done_o, err_o, vrf_re_o, vrf_we_o, ex_vec_instr_o, ex_valid_i;
  logic [6:0]  vrf_raddr_a_o, vrf_raddr_b_o, vrf_waddr_o;
  logic [31:0] vrf_rdata_a_i, vrf_rdata_b_i, vrf_wdata_o, ex_operand_a_o, ex_operand_b_o, ex_result_i;
  logic [3:0]  vrf_wbe_o;
  alu_op_e     ex_alu_op_o;
  logic [2:0]  ex_vsew_o;

  always #5 clk = ~clk;

  vcve2_vec_seq #(.VLEN(128)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i), .vx_i(vx_i), .scalar_i(scalar_i),
    .vl_i(vl_i), .vsew_i(vsew_i), .alu_op_i(alu_op_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .vrf_re_o(vrf_re_o), .vrf_raddr_a_o(vrf_raddr_a_o), .vrf_raddr_b_o(vrf_raddr_b_o),
    .vrf_rdata_a_i(vrf_rdata_a_i), .vrf_rdata_b_i(vrf_rdata_b_i),
    .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o), .vrf_wbe_o(vrf_wbe_o),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_vec_instr_o(ex_vec_instr_o), .ex_vsew_o(ex_vsew_o),
    .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i)
  );

  int unsigned n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [6:0] ad);
    return ((32'(ad) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] bsplat(input logic [31:0] s, input logic [2:0] sew);
    if (sew == 3'd0) return {s[7:0], s[7:0], s[7:0], s[7:0]};
    if (sew == 3'd1) return {s[15:0], s[15:0]};
    return s;
  endfunction

  function automatic logic [31:0] ex_model(input alu_op_e op, input logic [2:0] sew,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADD: begin
        if (sew == 3'd0) for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        else if (sew == 3'd1) for (int i = 0; i < 2; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        else r = a + b;
      end
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  // Behavioural VRF: data appears the cycle after a read and holds while re is low.
  always @(posedge clk) begin
    if (vrf_re_o) begin
      vrf_rdata_a_i <= pat(vrf_raddr_a_o);
      vrf_rdata_b_i <= pat(vrf_raddr_b_o);
    end
  end

  int unsigned stall_word = 0, stall_n = 0, stall_left = 0;
  always @(posedge clk) begin
    if (vrf_re_o && 32'(vrf_raddr_a_o[1:0]) == stall_word && stall_n != 0) stall_left <= stall_n;
    else if (ex_vec_instr_o && stall_left != 0) stall_left <= stall_left - 1;
  end
  assign ex_valid_i  = ex_vec_instr_o && (stall_left == 0);
  assign ex_result_i = ex_model(ex_alu_op_o, ex_vsew_o, ex_operand_a_o, ex_operand_b_o);

  typedef struct { logic [6:0] ad; logic [31:0] d; logic [3:0] be; } wr_t;
  wr_t         wq[$];
  logic [63:0] opq[$];
  wr_t         mon_e;
  alu_op_e     cur_op = ALU_ADD;
  logic [2:0]  cur_sew = 3'd0;
  int unsigned re_cnt = 0, we_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (vrf_re_o) re_cnt++;
    if (done_o) done_cnt++;
    if (vrf_we_o) begin
      we_cnt++;
      if (wq.size() == 0) chk("wr_unexpected", 64'(vrf_waddr_o), 64'h7FFF_FFFF);
      else begin
        mon_e = wq.pop_front();
        chk("wr_addr", 64'(vrf_waddr_o), 64'(mon_e.ad));
        chk("wr_data", 64'(vrf_wdata_o), 64'(mon_e.d));
        chk("wr_be",   64'(vrf_wbe_o),   64'(mon_e.be));
      end
    end
    if (ex_vec_instr_o && opq.size() != 0) begin
      chk("op_a",   64'(ex_operand_a_o), 64'(opq[0][63:32]));
      chk("op_b",   64'(ex_operand_b_o), 64'(opq[0][31:0]));
      chk("ex_op",  64'(ex_alu_op_o),    64'(cur_op));
      chk("ex_sew", 64'(ex_vsew_o),      64'(cur_sew));
      if (ex_valid_i) void'(opq.pop_front());
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ops"}, {ex_operand_a_o, ex_operand_b_o}, 64'd0);
    chk({tag, "_wdata"}, 64'(vrf_wdata_o), 64'd0);
    chk({tag, "_ctl"}, 64'({busy_o, done_o, err_o, vrf_re_o, vrf_raddr_a_o, vrf_raddr_b_o, vrf_we_o,
                            vrf_waddr_o, vrf_wbe_o, ex_alu_op_o, ex_vec_instr_o, ex_vsew_o}), 64'd0);
  endtask

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic x,
                       input logic [31:0] sc, input int unsigned vl, input logic [2:0] sew, input alu_op_e op);
    vs1_i = s1; vs2_i = s2; vd_i = d; vx_i = x; scalar_i = sc;
    vl_i = 5'(vl); vsew_i = sew; alu_op_i = op; start_i = 1'b1;
  endtask

  task automatic run(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic x,
                     input logic [31:0] sc, input int unsigned vl, input logic [2:0] sew, input alu_op_e op,
                     input int unsigned extra, input logic poke);
    int unsigned vmax, vle, nb, nw, lat, cyc, rem;
    logic err, seen;
    logic [31:0] a, b;
    err  = (sew > 3'd2);
    vmax = err ? 0 : (16 >> sew);
    vle  = (vl < vmax) ? vl : vmax;
    nb   = err ? 0 : (vle << sew);
    nw   = (nb + 3) / 4;
    for (int unsigned w = 0; w < nw; w++) begin
      a = pat({s1, 2'(w)});
      b = x ? bsplat(sc, sew) : pat({s2, 2'(w)});
      opq.push_back({a, b});
      rem = nb - 4 * w;
      wq.push_back('{ad: {d, 2'(w)}, d: ex_model(op, sew, a, b),
                     be: (rem >= 4) ? 4'hF : 4'((1 << rem) - 1)});
    end
    lat = (nw == 0) ? 1 : 3 * nw + 1 + extra;
    cur_op = op; cur_sew = sew;
    @(posedge clk); #1;
    drive(s1, s2, d, x, sc, vl, sew, op);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      if (poke && cyc == 2) begin
        start_i = 1'b1; vd_i = 5'd31; vs1_i = 5'd30;
      end
      seen = done_o;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency",   64'(cyc), 64'(lat));
    chk("err",       64'(err_o), 64'(err));
    chk("wq_left",   64'(wq.size()), 64'd0);
    chk("opq_left",  64'(opq.size()), 64'd0);
    wq.delete(); opq.delete();
    start_i = 1'b0;
  endtask

  int unsigned re0, we0, d0;
  logic [2:0]  t_sew[5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd1};
  int unsigned t_vl[5]  = '{13, 15, 5, 3, 7};

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 0, 3'd0, ALU_ADD);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk); #1 rst_ni = 1'b1;

    run(5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 4, 3'd2, ALU_ADD, 0, 1'b0);
    run(5'd4, 5'd5, 5'd6, 1'b0, 32'd0, 6, 3'd0, ALU_XOR, 0, 1'b0);
    run(5'd7, 5'd9, 5'd8, 1'b1, 32'h1234ABCD, 3, 3'd1, ALU_ADD, 0, 1'b0);
    run(5'd9, 5'd10, 5'd11, 1'b0, 32'd0, 20, 3'd0, ALU_OR, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      run(5'd13, 5'd14, 5'd15, 1'b0, 32'd0, t_vl[i], t_sew[i], ALU_AND, 0, 1'b0);

    re0 = re_cnt; we0 = we_cnt;
    run(5'd1, 5'd2, 5'd16, 1'b0, 32'd0, 0, 3'd2, ALU_ADD, 0, 1'b0);
    chk("vl0_no_re", 64'(re_cnt), 64'(re0));
    chk("vl0_no_we", 64'(we_cnt), 64'(we0));
    run(5'd1, 5'd2, 5'd17, 1'b0, 32'd0, 4, 3'd3, ALU_ADD, 0, 1'b0);
    chk("bad_sew_no_we", 64'(we_cnt), 64'(we0));

    // start held through FIN must be dropped; then a stalled word 1 with a start poke while busy
    stall_word = 1; stall_n = 5;
    run(5'd18, 5'd19, 5'd20, 1'b0, 32'd0, 4, 3'd2, ALU_SUB, 5, 1'b1);
    stall_n = 0;
    re0 = re_cnt; we0 = we_cnt;
    drive(5'd1, 5'd2, 5'd21, 1'b0, 32'd0, 4, 3'd2, ALU_ADD);
    @(posedge clk); #1 start_i = 1'b0;
    chk("fin_start_idle", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    chk("fin_start_ignored", 64'(busy_o), 64'd0);
    chk("fin_start_no_re", 64'(re_cnt), 64'(re0));

    // kill in the first WB cycle
    we0 = we_cnt; d0 = done_cnt;
    cur_op = ALU_ADD; cur_sew = 3'd2;
    opq.push_back({pat({5'd1, 2'd0}), pat({5'd2, 2'd0})});
    drive(5'd1, 5'd2, 5'd12, 1'b0, 32'd0, 4, 3'd2, ALU_ADD);
    @(posedge clk); #1 start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("kill_pre_wb", 64'(vrf_waddr_o), 64'({5'd12, 2'd0}));
    kill_i = 1'b1;
    #1 chk("kill_we", 64'(vrf_we_o), 64'd0);
    @(posedge clk); #1 kill_i = 1'b0;
    chk("kill_idle", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("kill_no_done", 64'(done_cnt), 64'(d0));
    chk("kill_no_write", 64'(we_cnt), 64'(we0));
    opq.delete();

    // asynchronous reset while in EX
    drive(5'd1, 5'd2, 5'd22, 1'b1, 32'hCAFE0001, 4, 3'd2, ALU_XOR);
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ex", 64'(ex_vec_instr_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle", 64'(busy_o), 64'd0);
    chk("rst_no_write", 64'(we_cnt), 64'(we0));
    chk("rst_no_done", 64'(done_cnt), 64'(d0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
